// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit instruction
// words and writes them to imem at word addresses 0..N-1. It holds the CPU in
// reset until a complete image has been written.
// Stream format: 2-byte little-endian word count N, then 4*N data bytes.
module imem_loader #(
    parameter int WIDTH = 32,   // instruction width, 4 bytes per word
    parameter int DEPTH = 512,  // imem depth in words, also the largest legal N
    parameter int AW    = 9     // imem word-address width
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_in_valid,
    input  logic [7:0]       i_in_data,
    output logic             o_in_ready,
    output logic             o_mem_we,
    output logic [AW-1:0]    o_mem_addr,
    output logic [WIDTH-1:0] o_mem_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    // DEPTH widened by one bit so a 16-bit count compares without truncation
    localparam logic [16:0] L_DEPTH = 17'(DEPTH);

    state_t            r_state;
    logic [15:0]       r_cnt;
    logic [15:0]       r_word_idx;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_asm;        // bytes 0..2 of the word being assembled
    logic              r_mem_we;
    logic [AW-1:0]     r_mem_addr;
    logic [WIDTH-1:0]  r_mem_wdata;
    logic              r_done;
    logic              r_err;
    logic              r_cpu_hold;

    logic              w_accept;
    logic              w_ready;
    logic [15:0]       w_hdr_n;
    logic              w_last;

    // ready and busy are both pure decodes of the load states
    assign w_ready  = (r_state == S_HDR0) || (r_state == S_HDR1) || (r_state == S_DATA);
    assign w_accept = i_in_valid && w_ready;
    // full count as it becomes known on the second header byte
    assign w_hdr_n  = {i_in_data, r_cnt[7:0]};
    // the word now being completed is the final one of the image
    assign w_last   = (r_word_idx == (r_cnt - 16'd1));

    // Loader FSM with registered write port and status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_word_idx  <= '0;
            r_byte_idx  <= '0;
            r_asm       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_hold  <= 1'b1;
        end else begin
            // write enable is a single-cycle pulse
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) r_state <= S_HDR0;
                end
                S_HDR0: begin
                    if (w_accept) begin
                        r_cnt[7:0] <= i_in_data;
                        r_state    <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (w_accept) begin
                        r_cnt[15:8] <= i_in_data;
                        r_byte_idx  <= '0;
                        r_word_idx  <= '0;
                        if (w_hdr_n == 16'd0) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else if ({1'b0, w_hdr_n} > L_DEPTH) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        if (r_byte_idx == 2'd3) begin
                            r_mem_wdata <= WIDTH'({i_in_data, r_asm});
                            r_mem_addr  <= r_word_idx[AW-1:0];
                            r_mem_we    <= 1'b1;
                            r_word_idx  <= r_word_idx + 16'd1;
                            r_byte_idx  <= 2'd0;
                            if (w_last) begin
                                r_state    <= S_DONE;
                                r_done     <= 1'b1;
                                r_cpu_hold <= 1'b0;
                            end
                        end else begin
                            r_asm[{r_byte_idx, 3'b000} +: 8] <= i_in_data;
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    // a new load re-arms the CPU hold and clears the old status
                    if (i_start) begin
                        r_state    <= S_HDR0;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_cpu_hold <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready  = w_ready;
    assign o_busy      = w_ready;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_cpu_hold  = r_cpu_hold;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: header table vectors plus directed load sequences,
// with a write monitor that models imem and checks write timing.
module tb_imem_loader;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic        i_in_valid;
    logic [7:0]  i_in_data;
    logic        o_in_ready;
    logic        o_mem_we;
    logic [8:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic        o_cpu_hold;

    imem_loader #(.WIDTH(32), .DEPTH(512), .AW(9)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_cpu_hold  (o_cpu_hold)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] tbmem [0:511];
    bit          wrf   [0:511];
    int          nwr;
    bit          tb_is4th;
    bit          pend4;
    bit          prev_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // imem model and write-timing monitor, sampled on the falling edge
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            pend4   = 1'b0;
            prev_we = 1'b0;
        end else begin
            if (o_mem_we) begin
                chk("we_width", {31'd0, prev_we}, 32'd0);
                tbmem[o_mem_addr] = o_mem_wdata;
                wrf[o_mem_addr]   = 1'b1;
                nwr++;
            end
            if (pend4 || o_mem_we) chk("we_latency", {31'd0, o_mem_we}, {31'd0, pend4});
            prev_we = o_mem_we;
            pend4   = i_in_valid && o_in_ready && tb_is4th;
        end
    end

    function automatic logic [31:0] wgen(input int kind, input int i);
        case (kind)
            0:       wgen = (i == 0) ? 32'h00000113 : 32'h00400093;
            1:       wgen = 32'h12345678 ^ (i * 32'h01010101);
            default: wgen = 32'hDEADBEEF + i;
        endcase
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) begin
            tbmem[i] = 'x;
            wrf[i]   = 1'b0;
        end
        nwr = 0;
    endtask

    // called at posedge+1; returns at posedge+1 just after the byte is taken
    task automatic put(input logic [7:0] b, input bit is4);
        int t;
        t          = 0;
        i_in_valid = 1'b1;
        i_in_data  = b;
        tb_is4th   = is4;
        @(negedge i_clk);
        while (!o_in_ready && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        if (!o_in_ready) begin
            chk("put_timeout", 32'd0, 32'd1);
            i_in_valid = 1'b0;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic idle_gap(input int gapmax);
        int g;
        if (gapmax > 0) begin
            g = $urandom_range(0, gapmax);
            if (g > 0) begin
                i_in_valid = 1'b0;
                repeat (g) begin
                    @(posedge i_clk);
                    #1;
                end
            end
        end
    endtask

    task automatic send_words(input int kind, input int first, input int n, input int gapmax);
        logic [31:0] w;
        for (int i = first; i < n; i++) begin
            w = wgen(kind, i);
            for (int k = 0; k < 4; k++) begin
                put(w[8*k +: 8], k == 3);
                idle_gap(gapmax);
            end
        end
    endtask

    task automatic check_image(input string nm, input int kind, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (!wrf[i] || tbmem[i] !== wgen(kind, i)) bad++;
        chk({nm, "_image"}, bad, 0);
        chk({nm, "_nwr"}, nwr, n);
    endtask

    // full load: start, header, data, then status and image checks
    task automatic load(input string nm, input int kind, input int n, input int gapmax);
        logic [15:0] nn;
        nn = 16'(n);
        clear_mem();
        pulse_start();
        put(nn[7:0], 1'b0);
        put(nn[15:8], 1'b0);
        send_words(kind, 0, n, gapmax);
        i_in_valid = 1'b0;
        tb_is4th   = 1'b0;
        repeat (2) @(negedge i_clk);
        chk({nm, "_done"}, {31'd0, o_done}, 32'd1);
        chk({nm, "_hold"}, {31'd0, o_cpu_hold}, 32'd0);
        chk({nm, "_busy"}, {31'd0, o_busy}, 32'd0);
        check_image(nm, kind, n);
        @(posedge i_clk);
        #1;
    endtask

    task automatic reset_pulse();
        i_rst_n    = 1'b0;
        i_in_valid = 1'b0;
        tb_is4th   = 1'b0;
        @(negedge i_clk);
        chk("rst_hold",  {31'd0, o_cpu_hold}, 32'd1);
        chk("rst_ready", {31'd0, o_in_ready}, 32'd0);
        chk("rst_we",    {31'd0, o_mem_we},   32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    typedef struct {
        string      name;
        logic [7:0] lo;
        logic [7:0] hi;
        logic       done;
        logic       err;
        logic       hold;
        logic       ready;
    } hv_t;

    hv_t tbl [5];

    initial begin
        // header vectors: count bytes in, status expected right after HDR1
        tbl[0] = '{"hdr_n0",    8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{"hdr_n513",  8'h01, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{"hdr_nffff", 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{"hdr_n4096", 8'h00, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{"hdr_n512",  8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1};

        i_rst_n    = 1'b0;
        i_start    = 1'b1;
        i_in_valid = 1'b0;
        i_in_data  = 8'h00;
        tb_is4th   = 1'b0;
        pend4      = 1'b0;
        prev_we    = 1'b0;
        clear_mem();

        // reset state, with start asserted throughout reset
        repeat (3) @(negedge i_clk);
        chk("t1_hold",  {31'd0, o_cpu_hold}, 32'd1);
        chk("t1_we",    {31'd0, o_mem_we},   32'd0);
        chk("t1_ready", {31'd0, o_in_ready}, 32'd0);
        chk("t1_done",  {31'd0, o_done},     32'd0);
        chk("t1_err",   {31'd0, o_err},      32'd0);
        chk("t1_addr",  {23'd0, o_mem_addr}, 32'd0);
        chk("t1_wdata", o_mem_wdata,         32'd0);
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("t1_idle_ready", {31'd0, o_in_ready}, 32'd0);
        chk("t1_idle_busy",  {31'd0, o_busy},     32'd0);
        @(posedge i_clk);
        #1;

        // two-word image, back-to-back
        load("t2", 0, 2, 0);
        chk("t2_addr_hold", {23'd0, o_mem_addr}, 32'd1);
        chk("t2_we_idle",   {31'd0, o_mem_we},   32'd0);

        // same image with random gaps
        load("t3_gap", 0, 2, 5);

        // header bounds table
        for (int v = 0; v < 5; v++) begin
            clear_mem();
            pulse_start();
            put(tbl[v].lo, 1'b0);
            put(tbl[v].hi, 1'b0);
            i_in_valid = 1'b0;
            @(negedge i_clk);
            chk({tbl[v].name, "_done"},  {31'd0, o_done},     {31'd0, tbl[v].done});
            chk({tbl[v].name, "_err"},   {31'd0, o_err},      {31'd0, tbl[v].err});
            chk({tbl[v].name, "_hold"},  {31'd0, o_cpu_hold}, {31'd0, tbl[v].hold});
            chk({tbl[v].name, "_ready"}, {31'd0, o_in_ready}, {31'd0, tbl[v].ready});
            repeat (2) @(negedge i_clk);
            chk({tbl[v].name, "_nwr"}, nwr, 0);
            @(posedge i_clk);
            #1;
        end
        reset_pulse();

        // largest legal image
        load("t4_n512", 1, 512, 0);
        chk("t4_last_addr", {23'd0, o_mem_addr}, 32'd511);
        chk("t4_last_data", o_mem_wdata, wgen(1, 511));

        // reset mid-load after a partial second word
        clear_mem();
        pulse_start();
        put(8'h02, 1'b0);
        put(8'h00, 1'b0);
        put(8'h13, 1'b0);
        put(8'h01, 1'b0);
        put(8'h00, 1'b0);
        put(8'h00, 1'b1);
        put(8'h93, 1'b0);
        reset_pulse();
        repeat (4) @(negedge i_clk);
        chk("t5_nwr",   nwr, 1);
        chk("t5_hold",  {31'd0, o_cpu_hold}, 32'd1);
        chk("t5_ready", {31'd0, o_in_ready}, 32'd0);
        @(posedge i_clk);
        #1;
        load("t5_reload", 0, 2, 0);

        // start while busy is ignored
        clear_mem();
        pulse_start();
        put(8'h02, 1'b0);
        put(8'h00, 1'b0);
        put(8'h13, 1'b0);
        put(8'h01, 1'b0);
        i_in_valid = 1'b0;
        @(negedge i_clk);
        chk("t6_busy", {31'd0, o_busy}, 32'd1);
        @(posedge i_clk);
        #1;
        pulse_start();
        put(8'h00, 1'b0);
        put(8'h00, 1'b1);
        send_words(0, 1, 2, 0);
        i_in_valid = 1'b0;
        tb_is4th   = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("t6_done", {31'd0, o_done}, 32'd1);
        check_image("t6_busy", 0, 2);
        @(posedge i_clk);
        #1;

        // restart from DONE re-holds the CPU; reload overwrites addr 0
        pulse_start();
        @(negedge i_clk);
        chk("t6_rs_hold", {31'd0, o_cpu_hold}, 32'd1);
        chk("t6_rs_done", {31'd0, o_done},     32'd0);
        chk("t6_rs_busy", {31'd0, o_busy},     32'd1);
        @(posedge i_clk);
        #1;
        load("t6_reload", 2, 1, 0);
        chk("t6_reload_addr", {23'd0, o_mem_addr}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // hard stop in case a sequence stalls beyond all per-byte bounds
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
